// File: rtl/display_pkg.sv
// Shared encodings for the three-digit multiplexed seven-segment scanner.
// Glyph table is active-low: bit 0 = segment a ... bit 7 = segment h.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_e;

  localparam int SEG_LSB = 0;
  localparam int SEG_MSB = 7;
  localparam int DOT_BIT = 8;
  localparam int DEN_LSB = 9;
  localparam int DEN_MSB = 11;

  localparam logic [11:0] ALL_OFF = 12'hFFF;

  // Digits 0..7; segment h is never lit
  localparam logic [0:7][7:0] GLYPH_TBL = {
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8
  };

endpackage

// File: rtl/display_scan_seg_decode.sv
// Combinational 3-bit code to active-low seven-segment glyph lookup.
// Uses the shared glyph table from display_pkg.
module seg_decode
  import display_pkg::*;
(
  input  logic [2:0] code_i,
  output logic [7:0] glyph_o
);

  assign glyph_o = GLYPH_TBL[code_i];

endmodule

// File: rtl/display_scan.sv
// Three-digit display scanner with double-buffered digit codes and dots.
// Define DISPLAY_SCAN_BLANK_EN to insert a one-cycle blank between digits.
module display_scan
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [8:0]  code_in,
  input  logic [2:0]  dot_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [11:0] segs,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(REFRESH_DIV - 1);
  localparam logic [1:0] LAST = 2'(NUM_DIGITS - 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic [11:0]   segs_q;
  logic          fd_q;
  logic          ready_q;
  logic          full_q;
  logic [8:0]    act_code_q;
  logic [2:0]    act_dot_q;
  logic [8:0]    sh_code_q;
  logic [2:0]    sh_dot_q;

  logic        capture;
  logic        expire;
  logic        last;
  logic        advance;
  logic        wrap;
  logic        commit;
  logic        full_d;
  logic [8:0]  act_code_d;
  logic [2:0]  act_dot_d;
  logic [1:0]  idx_d;
  logic [2:0]  dec_code;
  logic        dec_dot;
  logic [2:0]  dig_en;
  logic [7:0]  glyph;
  logic [11:0] show_segs;

  assign capture = load_valid && ready_q;
  assign expire  = (state_q == ST_SHOW) && (cnt_q == '0);
  assign last    = (idx_q == LAST);

`ifdef DISPLAY_SCAN_BLANK_EN
  assign advance = (state_q == ST_BLANK);
`else
  assign advance = expire;
`endif

  assign wrap = advance && last;

  // Shadow only lands between frames or when the scan is parked
  assign commit = full_q &&
    (!en || (state_q == ST_IDLE) || wrap);

  assign full_d = capture ? 1'b1 :
    (commit ? 1'b0 : full_q);

  assign act_code_d = commit ? sh_code_q : act_code_q;
  assign act_dot_d  = commit ? sh_dot_q  : act_dot_q;

  assign idx_d = !advance ? idx_q :
    (last ? 2'd0 : idx_q + 2'd1);

  always_comb begin
    dec_code = act_code_d[2:0];
    dec_dot  = act_dot_d[0];
    dig_en   = 3'b001;
    unique case (1'b1)
      idx_d == 2'd1: begin
        dec_code = act_code_d[5:3];
        dec_dot  = act_dot_d[1];
        dig_en   = 3'b010;
      end
      idx_d == 2'd2: begin
        dec_code = act_code_d[8:6];
        dec_dot  = act_dot_d[2];
        dig_en   = 3'b100;
      end
      default: ;
    endcase
  end

  seg_decode u_dec (
    .code_i  (dec_code),
    .glyph_o (glyph)
  );

  always_comb begin
    show_segs = ALL_OFF;
    show_segs[DEN_MSB:DEN_LSB] = ~dig_en;
    show_segs[DOT_BIT] = ~dec_dot;
    show_segs[SEG_MSB:SEG_LSB] = glyph;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= RELOAD;
      idx_q      <= 2'd0;
      segs_q     <= ALL_OFF;
      fd_q       <= 1'b0;
      ready_q    <= 1'b1;
      full_q     <= 1'b0;
      act_code_q <= '0;
      act_dot_q  <= '0;
      sh_code_q  <= '0;
      sh_dot_q   <= '0;
    end else begin
      fd_q       <= 1'b0;
      full_q     <= full_d;
      ready_q    <= ~full_d;
      act_code_q <= act_code_d;
      act_dot_q  <= act_dot_d;
      if (capture) begin
        sh_code_q <= code_in;
        sh_dot_q  <= dot_in;
      end
      if (!en) begin
        state_q <= ST_IDLE;
        cnt_q   <= RELOAD;
        idx_q   <= 2'd0;
        segs_q  <= ALL_OFF;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            state_q <= ST_SHOW;
            cnt_q   <= RELOAD;
            idx_q   <= idx_d;
            segs_q  <= show_segs;
          end
          ST_SHOW: begin
            if (expire) begin
`ifdef DISPLAY_SCAN_BLANK_EN
              state_q <= ST_BLANK;
              segs_q  <= ALL_OFF;
`else
              state_q <= ST_SHOW;
              cnt_q   <= RELOAD;
              idx_q   <= idx_d;
              segs_q  <= show_segs;
              fd_q    <= wrap;
`endif
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          ST_BLANK: begin
            state_q <= ST_SHOW;
            cnt_q   <= RELOAD;
            idx_q   <= idx_d;
            segs_q  <= show_segs;
            fd_q    <= wrap;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign segs       = segs_q;
  assign digit_idx  = idx_q;
  assign frame_done = fd_q;
  assign load_ready = ready_q;

endmodule

// File: tb/tb_display_scan.sv
// Randomised bench for display_scan against a frame-position reference model.
// Build with DISPLAY_SCAN_BLANK_EN to check the blanking variant.
module tb_display_scan;

  localparam int RD = 4;
`ifdef DISPLAY_SCAN_BLANK_EN
  localparam int S = RD + 1;
`else
  localparam int S = RD;
`endif
  localparam int F = 3 * S;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [8:0]  code_in;
  logic [2:0]  dot_in;
  logic        load_valid;
  logic        load_ready;
  logic [11:0] segs;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  bit         m_run;
  int         m_t;
  logic [8:0] m_code;
  logic [2:0] m_dot;
  bit         m_full;
  logic [8:0] m_sh_code;
  logic [2:0] m_sh_dot;
  bit         m_fd;
  int         m_caps;
  logic [7:0] pat [8];

  always #5 clk = ~clk;

  display_scan #(.REFRESH_DIV(RD), .NUM_DIGITS(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .code_in    (code_in),
    .dot_in     (dot_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .segs       (segs),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  function automatic void model_reset();
    m_run = 0; m_t = 0; m_code = '0; m_dot = '0;
    m_full = 0; m_sh_code = '0; m_sh_dot = '0; m_fd = 0;
  endfunction

  // Time within the frame decides digit, slot phase and frame wrap
  function automatic void model_edge();
    bit cap, wrapn, com;
    cap = load_valid && !m_full;
    wrapn = m_run && en && ((m_t + 1) % F == 0);
    com = m_full && (!en || !m_run || wrapn);
    if (com) begin m_code = m_sh_code; m_dot = m_sh_dot; end
    if (cap) begin
      m_sh_code = code_in; m_sh_dot = dot_in; m_caps++;
    end
    m_full = cap || (m_full && !com);
    m_fd = wrapn;
    if (!en) begin m_run = 0; m_t = 0; end
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t = (m_t + 1) % F;
  endfunction

  function automatic logic [15:0] exp_vec();
    int d;
    logic [2:0] c, e;
    logic [11:0] s;
    d = m_run ? (m_t / S) % 3 : 0;
    if (!m_run || (m_t % S) >= RD) s = 12'hFFF;
    else begin
      c = m_code[3*d +: 3];
      e = ~(3'b001 << d);
      s = {e, ~m_dot[d], ~pat[c]};
    end
    return {s, 2'(d), m_fd, !m_full};
  endfunction

  always @(posedge clk) if (!rst) model_edge();

  task automatic test_reset();
    rst = 1; en = 0; load_valid = 0; code_in = '0; dot_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (segs !== 12'hFFF) begin failures++;
      $display("FAIL reset_segs got=%h exp=fff", segs); end
    checks++;
    if (digit_idx !== 2'd0) begin failures++;
      $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
    checks++;
    if (frame_done !== 1'b0) begin failures++;
      $display("FAIL reset_fd got=%b exp=0", frame_done); end
    checks++;
    if (load_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ready got=%b exp=1", load_ready); end
    rst = 0;
  endtask

  task automatic test_scan_no_load();
    int last_fd, gap_checks;
    last_fd = -1; gap_checks = 0;
    en = 1; load_valid = 0;
    for (int i = 0; i < 5 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL scan t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
      if (frame_done) begin
        if (last_fd >= 0) begin
          checks++; gap_checks++;
          if (i - last_fd != F) begin failures++;
            $display("FAIL fd_period got=%0d exp=%0d", i - last_fd, F); end
        end
        last_fd = i;
      end
      code_in = 9'($urandom); dot_in = 3'($urandom);
    end
    checks++;
    if (gap_checks < 3) begin failures++;
      $display("FAIL fd_count got=%0d exp>=3", gap_checks); end
  endtask

  task automatic test_load_idle();
    en = 0;
    repeat (2) @(negedge clk);
    code_in = 9'o765; dot_in = 3'b010; load_valid = 1;
    @(negedge clk);
    load_valid = 0;
    repeat (2) @(negedge clk);
    en = 1;
    for (int i = 0; i < 2 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL load_idle t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
      if (i == 0) begin
        checks++;
        if (segs !== 12'hD92) begin failures++;
          $display("FAIL first_glyph got=%h exp=d92", segs); end
      end
      if (i == S) begin
        checks++;
        if (segs !== 12'hA82) begin failures++;
          $display("FAIL digit1_dot got=%h exp=a82", segs); end
      end
      if (i == 2 * S) begin
        checks++;
        if (segs !== 12'h7F8) begin failures++;
          $display("FAIL digit2_glyph got=%h exp=7f8", segs); end
      end
    end
  endtask

  task automatic test_load_mid_frame();
    bit found;
    found = 0;
    en = 1;
    for (int i = 0; i < 4 * F && !found; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL mid_wait t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
      found = frame_done;
    end
    checks++;
    if (!found) begin failures++;
      $display("FAIL mid_timeout got=0 exp=frame_done"); end
    code_in = 9'($urandom); dot_in = 3'($urandom); load_valid = 1;
    for (int i = 0; i < 3 * F; i++) begin
      @(negedge clk);
      load_valid = 0;
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL mid_frame t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int caps0, falls;
    bit prev_ready;
    caps0 = m_caps; falls = 0; prev_ready = load_ready;
    en = 1; load_valid = 1;
    code_in = 9'($urandom); dot_in = 3'($urandom);
    for (int i = 0; i < 4 * F; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL b2b t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
      if (prev_ready && !load_ready) falls++;
      prev_ready = load_ready;
      if (!load_ready) begin
        code_in = 9'($urandom); dot_in = 3'($urandom);
      end
    end
    load_valid = 0;
    checks++;
    if (falls !== m_caps - caps0 || falls < 2) begin failures++;
      $display("FAIL b2b_caps got=%0d exp=%0d", falls, m_caps - caps0); end
  endtask

  task automatic test_en_drop();
    bit found;
    int n0;
    found = 0; n0 = 0;
    en = 1;
    for (int i = 0; i < 4 * F && !found; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL drop_wait t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
      found = (digit_idx == 2'd1) && (segs != 12'hFFF);
    end
    checks++;
    if (!found) begin failures++;
      $display("FAIL drop_timeout got=0 exp=digit1"); end
    en = 0;
    @(negedge clk);
    checks++;
    if (segs !== 12'hFFF || digit_idx !== 2'd0) begin failures++;
      $display("FAIL drop_idle got=%h/%0d exp=fff/0", segs, digit_idx); end
    en = 1;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL resume t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
      if (i < S && segs[11:9] == 3'b110) n0++;
    end
    checks++;
    if (n0 !== RD) begin failures++;
      $display("FAIL resume_slot got=%0d exp=%0d", n0, RD); end
  endtask

  task automatic test_reset_mid();
    en = 1; code_in = 9'($urandom); dot_in = 3'($urandom); load_valid = 1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      load_valid = 0;
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL pre_rst t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
    end
    load_valid = 1; code_in = 9'($urandom);
    @(posedge clk);
    #2 rst = 1;
    #1;
    checks++;
    if ({segs, digit_idx, frame_done, load_ready} !== {12'hFFF, 2'd0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL async_rst got=%h/%0d/%b/%b exp=fff/0/0/1",
        segs, digit_idx, frame_done, load_ready);
    end
    model_reset();
    load_valid = 0;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < F; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL post_rst t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      checks++;
      if ({segs, digit_idx, frame_done, load_ready} !== exp_vec()) begin
        failures++;
        $display("FAIL random t=%0t got=%h exp=%h", $time,
          {segs, digit_idx, frame_done, load_ready}, exp_vec());
      end
      en = ($urandom_range(0, 15) != 0);
      load_valid = ($urandom_range(0, 3) == 0);
      code_in = 9'($urandom); dot_in = 3'($urandom);
    end
  endtask

  initial begin
    pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07};
    m_caps = 0;
    test_reset();
    test_scan_no_load();
    test_load_idle();
    test_load_mid_frame();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 The block SHALL expose parameter REFRESH_DIV, default 50000, clock cycles each digit is shown (minimum 2).
REQ-002 The block SHALL expose parameter NUM_DIGITS, default 3, digits scanned (fixed 3; other values unsupported).
REQ-003 The block SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port en  input  1  scan enable; low forces idle.
REQ-006 The block SHALL have port code_in  input  9  three 3-bit digit codes, digit k at [3k+2:3k].
REQ-007 The block SHALL have port dot_in  input  3  per-digit dot request, bit k for digit k, active-high.
REQ-008 The block SHALL have port load_valid  input  1  code_in/dot_in offered for capture.
REQ-009 The block SHALL have port load_ready  output  1  shadow register free.
REQ-010 The block SHALL have port segs  output  12  [7:0] segments a-h, [8] dot, [11:9] digit enables; all active-low.
REQ-011 The block SHALL have port digit_idx  output  2  digit currently driven (0..2).
REQ-012 The block SHALL have port frame_done  output  1  one-cycle pulse at end of digit 2 slot.

Function
- REQ-013 States SHALL be IDLE, SHOW, BLANK; registered outputs throughout.
- REQ-014 IDLE: segs = 12'hFFF, digit_idx = 0; en high -> SHOW digit 0 next cycle.
- REQ-015 SHOW: segs[7:0] = glyph(active code of digit_idx), segs[8] = ~dot, only segs[9+digit_idx] low; held exactly REFRESH_DIV cycles via down-counter.
- REQ-016 Counter expiry SHALL go to BLANK (macro on) or directly to SHOW of next digit (macro off); digit_idx wraps 2 -> 0.
- REQ-017 frame_done SHALL pulse in the cycle digit_idx wraps 2 -> 0.
- REQ-018 Handshake: capture when load_valid && load_ready; load_ready deasserts next cycle, reasserts the cycle after commit.
- REQ-019 Shadow SHALL commit to active registers only at frame wrap or while IDLE (no tearing mid-frame); commit and new capture in same cycle: commit old, capture new.
- REQ-020 en low in any state SHALL return to IDLE next cycle, counter reloaded; pending shadow committed on entry to IDLE.
- REQ-021 Counter width SHALL be $clog2(REFRESH_DIV); no overflow paths.

Reset
- REQ-022 rst SHALL asynchronously force IDLE, segs = 12'hFFF, digit_idx = 0, frame_done = 0, load_ready = 1, active codes = 0, dots = 0, shadow empty.
- REQ-023 Reset mid-frame SHALL discard shadow and active data; no partial glyph after release.

Configuration
- REQ-024 Macro DISPLAY_SCAN_BLANK_EN defined: BLANK state inserted for 1 cycle between digits, segs = 12'hFFF (anti-ghosting).
- REQ-025 Macro undefined: BLANK absent; digit slots contiguous, frame = 3*REFRESH_DIV cycles.

Structure
- REQ-026 Package display_pkg SHALL hold state encoding, segs field bit indices, ALL_OFF = 12'hFFF and the 8-entry active-low glyph table.
- REQ-027 Sub-module seg_decode (combinational, 3-bit code -> 8-bit glyph from display_pkg) SHALL be instantiated once.

Verification (bench REFRESH_DIV = 4)
- REQ-028 rst pulse mid-SHOW -> segs 12'hFFF same cycle, load_ready = 1, digit_idx = 0.
- REQ-029 en = 1, no loads -> digit enables cycle 110,101,011 ([11:9]) every 4 cycles (5 with macro); frame_done every 12 (15) cycles.
- REQ-030 load code_in = 9'o765, dot_in = 3'b010 while IDLE -> first SHOW shows glyph 5, dot only on digit 1.
- REQ-031 load at digit 0 mid-frame -> old codes shown until frame_done, new from next digit 0; load_ready low until commit +1.
- REQ-032 load_valid held high through commit -> two captures, no data lost or duplicated.
- REQ-033 en dropped during digit 1 -> segs 12'hFFF next cycle; en reasserted -> resumes at digit 0 with full 4-cycle slot.
